// File: rtl/imem_responder.sv
// imem_responder: word-organised instruction store with a fixed-latency read
// response, a single-cycle write path and cancellation of an in-flight read.
// A read is accepted when proc_req and mem_rdy are both high. The data and the
// misaligned flag are captured at acceptance. They are presented with a
// one-cycle valid pulse LATENCY cycles later. No response is given for writes.
module imem_responder #(
  parameter int unsigned     bits     = 32,
  parameter int unsigned     DEPTH    = 1024,
  parameter int unsigned     LATENCY  = 2,
  parameter logic [bits-1:0] NOP_WORD = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            proc_req,
  input  logic            we,
  input  logic [bits-1:0] addr,
  input  logic [bits-1:0] wdata,
  input  logic            flush,
  output logic            mem_rdy,
  output logic            valid,
  output logic [bits-1:0] rdata,
  output logic            err
);

  localparam int unsigned AW = $clog2(DEPTH);
  // The wait counter only ever holds values up to LATENCY-1.
  localparam int unsigned CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic          SINGLE   = (LATENCY == 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_nxt_s;
  logic              mem_rdy_r;
  logic              valid_r;
  logic              err_r;
  logic [bits-1:0]   rdata_r;
  logic [bits-1:0]   pend_data_r;
  logic              pend_err_r;
  logic [bits-1:0]   mem_r [DEPTH];

  logic              accept_s;
  logic              rd_acc_s;
  logic              wr_acc_s;
  logic [AW-1:0]     idx_s;
  logic              misaligned_s;
  logic [bits-1:0]   rd_word_s;
  logic [bits-1:0]   resp_data_s;
  logic              resp_err_s;
  logic              unused_addr_s;

  assign accept_s     = proc_req & mem_rdy_r;
  assign rd_acc_s     = accept_s & ~we;
  assign wr_acc_s     = accept_s & we;
  assign idx_s        = addr[AW+1:2];
  assign misaligned_s = (addr[1:0] != 2'b00);
  assign rd_word_s    = misaligned_s ? NOP_WORD : mem_r[idx_s];
  // Upper address bits alias by design; they are deliberately unused.
  assign unused_addr_s = ^addr;

  // Write port of the store; the store is never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[idx_s] <= wdata;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE, ST_RESP: begin
        // flush only cancels older reads, so a new read is always kept.
        if (rd_acc_s) begin
          if (SINGLE) begin
            state_nxt_s = ST_RESP;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = CNT_INIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CNT_ONE) begin
          state_nxt_s = ST_RESP;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Select the response source: captured data after a wait, or the live read.
  always_comb begin
    resp_data_s = rd_word_s;
    resp_err_s  = misaligned_s;
    if (state_r == ST_WAIT) begin
      resp_data_s = pend_data_r;
      resp_err_s  = pend_err_r;
    end else begin
      resp_data_s = rd_word_s;
      resp_err_s  = misaligned_s;
    end
  end

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      mem_rdy_r <= 1'b0;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      rdata_r   <= '0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      mem_rdy_r <= (state_nxt_s != ST_WAIT);
      valid_r   <= (state_nxt_s == ST_RESP);
      if (state_nxt_s == ST_RESP) begin
        rdata_r <= resp_data_s;
        err_r   <= resp_err_s;
      end else begin
        err_r   <= 1'b0;
      end
    end
  end

  // Capture the read word at acceptance so the response reflects that instant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_data_r <= '0;
      pend_err_r  <= 1'b0;
    end else if (rd_acc_s) begin
      pend_data_r <= rd_word_s;
      pend_err_r  <= misaligned_s;
    end
  end

  assign mem_rdy = mem_rdy_r;
  assign valid   = valid_r;
  assign rdata   = rdata_r;
  assign err     = err_r;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances with LATENCY 2, 1 and 3.
// Index 0 is LATENCY=2, index 1 is LATENCY=1, index 2 is LATENCY=3.
module tb_imem_responder;

  localparam logic [31:0] W10 = 32'hDEADBEEF;
  localparam logic [31:0] W14 = 32'h00500093;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        req_v   [3];
  logic        we_v    [3];
  logic        flush_v [3];
  logic [31:0] addr_v  [3];
  logic [31:0] wdata_v [3];
  logic        rdy_v   [3];
  logic        valid_v [3];
  logic        err_v   [3];
  logic [31:0] rdata_v [3];

  int checks = 0;
  int errors = 0;

  imem_responder #(.bits(32), .DEPTH(1024), .LATENCY(2), .NOP_WORD(32'h00000013)) u_l2 (
    .clk(clk), .rst(rst), .proc_req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .flush(flush_v[0]), .mem_rdy(rdy_v[0]), .valid(valid_v[0]),
    .rdata(rdata_v[0]), .err(err_v[0]));

  imem_responder #(.bits(32), .DEPTH(1024), .LATENCY(1), .NOP_WORD(32'h00000013)) u_l1 (
    .clk(clk), .rst(rst), .proc_req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .flush(flush_v[1]), .mem_rdy(rdy_v[1]), .valid(valid_v[1]),
    .rdata(rdata_v[1]), .err(err_v[1]));

  imem_responder #(.bits(32), .DEPTH(1024), .LATENCY(3), .NOP_WORD(32'h00000013)) u_l3 (
    .clk(clk), .rst(rst), .proc_req(req_v[2]), .we(we_v[2]), .addr(addr_v[2]),
    .wdata(wdata_v[2]), .flush(flush_v[2]), .mem_rdy(rdy_v[2]), .valid(valid_v[2]),
    .rdata(rdata_v[2]), .err(err_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic rd_start(input int i, input logic [31:0] a);
    req_v[i]  = 1'b1;
    we_v[i]   = 1'b0;
    addr_v[i] = a;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_v[i] = 1'b0; we_v[i] = 1'b0; flush_v[i] = 1'b0;
      addr_v[i] = 32'h0; wdata_v[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy_v[i] !== 1'b0) begin errors++; $display("FAIL reset_rdy[%0d] got %b exp 0", i, rdy_v[i]); end
      checks++;
      if (valid_v[i] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got %b exp 0", i, valid_v[i]); end
      checks++;
      if (rdata_v[i] !== 32'h0 || err_v[i] !== 1'b0) begin
        errors++; $display("FAIL reset_rdata_err[%0d] got %h/%b exp 0/0", i, rdata_v[i], err_v[i]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy_v[i] !== 1'b1) begin errors++; $display("FAIL release_rdy[%0d] got %b exp 1", i, rdy_v[i]); end
    end
  endtask

  task automatic test_preload();
    for (int i = 0; i < 3; i++) begin
      req_v[i] = 1'b1; we_v[i] = 1'b1; addr_v[i] = 32'h10; wdata_v[i] = W10;
      @(negedge clk);
      addr_v[i] = 32'h14; wdata_v[i] = W14;
      checks++;
      if (valid_v[i] !== 1'b0 || rdy_v[i] !== 1'b1) begin
        errors++; $display("FAIL write1[%0d] valid/rdy got %b/%b exp 0/1", i, valid_v[i], rdy_v[i]);
      end
      @(negedge clk);
      req_v[i] = 1'b0; we_v[i] = 1'b0;
      checks++;
      if (valid_v[i] !== 1'b0 || rdy_v[i] !== 1'b1) begin
        errors++; $display("FAIL write2[%0d] valid/rdy got %b/%b exp 0/1", i, valid_v[i], rdy_v[i]);
      end
    end
  endtask

  task automatic test_latency();
    rd_start(0, 32'h10);
    @(negedge clk);
    req_v[0] = 1'b0;
    checks++;
    if (rdy_v[0] !== 1'b0 || valid_v[0] !== 1'b0) begin
      errors++; $display("FAIL lat_wait rdy/valid got %b/%b exp 0/0", rdy_v[0], valid_v[0]);
    end
    @(negedge clk);
    checks++;
    if (valid_v[0] !== 1'b1 || rdata_v[0] !== W10 || err_v[0] !== 1'b0) begin
      errors++; $display("FAIL lat_resp got v=%b d=%h e=%b exp v=1 d=%h e=0", valid_v[0], rdata_v[0], err_v[0], W10);
    end
    checks++;
    if (rdy_v[0] !== 1'b1) begin errors++; $display("FAIL lat_resp_rdy got %b exp 1", rdy_v[0]); end
    rd_start(0, 32'h14);
    @(negedge clk);
    req_v[0] = 1'b0;
    checks++;
    if (valid_v[0] !== 1'b0 || rdy_v[0] !== 1'b0 || rdata_v[0] !== W10) begin
      errors++; $display("FAIL b2b_wait got v=%b r=%b d=%h exp v=0 r=0 d=%h", valid_v[0], rdy_v[0], rdata_v[0], W10);
    end
    @(negedge clk);
    checks++;
    if (valid_v[0] !== 1'b1 || rdata_v[0] !== W14) begin
      errors++; $display("FAIL b2b_resp got v=%b d=%h exp v=1 d=%h", valid_v[0], rdata_v[0], W14);
    end
    @(negedge clk);
    checks++;
    if (valid_v[0] !== 1'b0 || rdy_v[0] !== 1'b1) begin
      errors++; $display("FAIL b2b_idle got v=%b r=%b exp v=0 r=1", valid_v[0], rdy_v[0]);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] seq_a [3];
    logic [31:0] seq_d [3];
    seq_a[0] = 32'h10; seq_a[1] = 32'h14; seq_a[2] = 32'h10;
    seq_d[0] = W10;    seq_d[1] = W14;    seq_d[2] = W10;
    rd_start(1, seq_a[0]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k < 2) addr_v[1] = seq_a[k+1];
      else req_v[1] = 1'b0;
      checks++;
      if (valid_v[1] !== 1'b1 || rdata_v[1] !== seq_d[k] || rdy_v[1] !== 1'b1) begin
        errors++; $display("FAIL stream[%0d] got v=%b d=%h r=%b exp v=1 d=%h r=1", k, valid_v[1], rdata_v[1], rdy_v[1], seq_d[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (valid_v[1] !== 1'b0 || rdy_v[1] !== 1'b1) begin
      errors++; $display("FAIL stream_end got v=%b r=%b exp v=0 r=1", valid_v[1], rdy_v[1]);
    end
  endtask

  task automatic test_misaligned_alias();
    rd_start(0, 32'h12);
    @(negedge clk);
    req_v[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_v[0] !== 1'b1 || rdata_v[0] !== NOP || err_v[0] !== 1'b1) begin
      errors++; $display("FAIL misaligned got v=%b d=%h e=%b exp v=1 d=%h e=1", valid_v[0], rdata_v[0], err_v[0], NOP);
    end
    @(negedge clk);
    checks++;
    if (err_v[0] !== 1'b0 || valid_v[0] !== 1'b0 || rdata_v[0] !== NOP) begin
      errors++; $display("FAIL misaligned_after got v=%b e=%b d=%h exp v=0 e=0 d=%h", valid_v[0], err_v[0], rdata_v[0], NOP);
    end
    rd_start(0, 32'h1010);
    @(negedge clk);
    req_v[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_v[0] !== 1'b1 || rdata_v[0] !== W10 || err_v[0] !== 1'b0) begin
      errors++; $display("FAIL alias got v=%b d=%h e=%b exp v=1 d=%h e=0", valid_v[0], rdata_v[0], err_v[0], W10);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    rd_start(2, 32'h10);
    @(negedge clk);
    req_v[2] = 1'b0;
    flush_v[2] = 1'b1;
    checks++;
    if (rdy_v[2] !== 1'b0) begin errors++; $display("FAIL flush_wait_rdy got %b exp 0", rdy_v[2]); end
    @(negedge clk);
    flush_v[2] = 1'b0;
    checks++;
    if (rdy_v[2] !== 1'b1 || valid_v[2] !== 1'b0) begin
      errors++; $display("FAIL flush_idle got r=%b v=%b exp r=1 v=0", rdy_v[2], valid_v[2]);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (valid_v[2] !== 1'b0) begin errors++; $display("FAIL flush_no_valid[%0d] got %b exp 0", k, valid_v[2]); end
    end
    // Flush together with a new request keeps the new request.
    rd_start(2, 32'h14);
    flush_v[2] = 1'b1;
    @(negedge clk);
    req_v[2] = 1'b0;
    flush_v[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_v[2] !== 1'b0) begin errors++; $display("FAIL flush_req_early got %b exp 0", valid_v[2]); end
    @(negedge clk);
    checks++;
    if (valid_v[2] !== 1'b1 || rdata_v[2] !== W14) begin
      errors++; $display("FAIL flush_req_resp got v=%b d=%h exp v=1 d=%h", valid_v[2], rdata_v[2], W14);
    end
    // Flush during RESP with a new read: valid stays shown, new read kept.
    rd_start(2, 32'h10);
    flush_v[2] = 1'b1;
    @(negedge clk);
    req_v[2] = 1'b0;
    flush_v[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (valid_v[2] !== 1'b1 || rdata_v[2] !== W10) begin
      errors++; $display("FAIL flush_in_resp got v=%b d=%h exp v=1 d=%h", valid_v[2], rdata_v[2], W10);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    rd_start(2, 32'h14);
    @(negedge clk);
    req_v[2] = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (rdy_v[2] !== 1'b0 || valid_v[2] !== 1'b0 || rdata_v[2] !== 32'h0 || err_v[2] !== 1'b0) begin
      errors++; $display("FAIL async_rst got r=%b v=%b d=%h e=%b exp all 0", rdy_v[2], valid_v[2], rdata_v[2], err_v[2]);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (valid_v[2] !== 1'b0) begin errors++; $display("FAIL rst_no_valid[%0d] got %b exp 0", k, valid_v[2]); end
    end
    rd_start(2, 32'h10);
    @(negedge clk);
    req_v[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (valid_v[2] !== 1'b1 || rdata_v[2] !== W10) begin
      errors++; $display("FAIL retained got v=%b d=%h exp v=1 d=%h", valid_v[2], rdata_v[2], W10);
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_latency();
    test_streaming();
    test_misaligned_alias();
    test_flush();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "timeout");
  end

endmodule
